// File: rtl/core_alu_issue.sv
//==============================================================================
// Module   : core_alu_issue
// Brief    : Two-stage issue/result wrapper around a combinational core_alu.
//            Stage A registers the operands, function and destination that
//            drive the ALU; stage B captures the ALU result and presents it
//            to writeback over a valid/ready channel. Read-after-write
//            hazards against in-flight producers hold off the decode stage.
// Config   : `define CORE_ALU_ISSUE_FORWARD_EN to forward the stage B result
//            into operand capture instead of stalling until B drains.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

// Fallback bus definitions for builds that do not pull in the shared defines.
`ifndef MemByteBus
`define MemByteBus 31:0
`endif
`ifndef ALUFuncBus
`define ALUFuncBus 3:0
`endif
`ifndef ALUFunc_ADD
`define ALUFunc_ADD 4'd0
`endif

module core_alu_issue (
   input  logic               clk,
   input  logic               rst,
   // decode side
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [`ALUFuncBus] in_func,
   input  logic [4:0]         in_rs1_addr,
   input  logic [4:0]         in_rs2_addr,
   input  logic [`MemByteBus] in_rs1_data,
   input  logic [`MemByteBus] in_rs2_data,
   input  logic [`MemByteBus] in_imm,
   input  logic               in_use_imm,
   input  logic [4:0]         in_rd_addr,
   // core_alu side
   output logic               alu_eval_en,
   output logic [`MemByteBus] alu_opnum1,
   output logic [`MemByteBus] alu_opnum2,
   output logic [`ALUFuncBus] alu_func,
   input  logic [`MemByteBus] alu_res,
   // writeback side
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4:0]         out_rd_addr,
   output logic [`MemByteBus] out_res
);

   // Stage A (issue) registers
   logic               a_valid_q,  a_valid_d;
   logic [`MemByteBus] a_opnum1_q, a_opnum1_d;
   logic [`MemByteBus] a_opnum2_q, a_opnum2_d;
   logic [`ALUFuncBus] a_func_q,   a_func_d;
   logic [4:0]         a_rd_q,     a_rd_d;

   // Stage B (result) registers
   logic               b_valid_q,  b_valid_d;
   logic [`MemByteBus] b_res_q,    b_res_d;
   logic [4:0]         b_rd_q,     b_rd_d;

   // Handshake and hazard terms
   logic               b_ready;
   logic               a_ready;
   logic               hazard_a;
   logic               hazard;
   logic               accept;
   logic               b_load;
   logic [`MemByteBus] rs1_val;
   logic [`MemByteBus] rs2_val;

   // B can take a new result when empty or when its current one leaves now;
   // A can take a new instruction when empty or when it moves into B now.
   assign b_ready = !b_valid_q || out_ready;
   assign a_ready = !a_valid_q || b_ready;
   assign b_load  = a_valid_q && b_ready;

   // The stage A producer's result does not exist yet, so any source match
   // against it must stall. x0 never carries a dependency; rs2 only counts
   // when it is actually used as an operand.
   assign hazard_a = a_valid_q && (a_rd_q != 5'd0) &&
                     ((a_rd_q == in_rs1_addr) ||
                      ((a_rd_q == in_rs2_addr) && !in_use_imm));

`ifdef CORE_ALU_ISSUE_FORWARD_EN
   logic fwd_rs1;
   logic fwd_rs2;

   // Stage B already holds its final value, so a source match there is
   // satisfied by bypassing out_res into the capture path.
   assign fwd_rs1 = b_valid_q && (b_rd_q != 5'd0) && (b_rd_q == in_rs1_addr);
   assign fwd_rs2 = b_valid_q && (b_rd_q != 5'd0) && (b_rd_q == in_rs2_addr);
   assign rs1_val = fwd_rs1 ? b_res_q : in_rs1_data;
   assign rs2_val = fwd_rs2 ? b_res_q : in_rs2_data;
   assign hazard  = hazard_a;
`else
   logic hazard_b;

   // Without a bypass, the register file is only current once B has been
   // handed to writeback, so matches against B stall as well.
   assign hazard_b = b_valid_q && (b_rd_q != 5'd0) &&
                     ((b_rd_q == in_rs1_addr) ||
                      ((b_rd_q == in_rs2_addr) && !in_use_imm));
   assign rs1_val  = in_rs1_data;
   assign rs2_val  = in_rs2_data;
   assign hazard   = hazard_a || hazard_b;
`endif

   assign in_ready = a_ready && !hazard;
   assign accept   = in_valid && in_ready;

   // Stage A next state: capture on accept, otherwise empty once drained into B
   always_comb begin
      a_valid_d  = a_valid_q;
      a_opnum1_d = a_opnum1_q;
      a_opnum2_d = a_opnum2_q;
      a_func_d   = a_func_q;
      a_rd_d     = a_rd_q;
      if (accept) begin
         a_valid_d  = 1'b1;
         a_opnum1_d = rs1_val;
         a_opnum2_d = in_use_imm ? in_imm : rs2_val;
         a_func_d   = in_func;
         a_rd_d     = in_rd_addr;
      end else if (b_ready) begin
         a_valid_d  = 1'b0;
      end
   end

   // Stage B next state: load the ALU result from A, otherwise drop on handshake
   always_comb begin
      b_valid_d = b_valid_q;
      b_res_d   = b_res_q;
      b_rd_d    = b_rd_q;
      if (b_load) begin
         b_valid_d = 1'b1;
         b_res_d   = alu_res;
         b_rd_d    = a_rd_q;
      end else if (out_ready) begin
         b_valid_d = 1'b0;
      end
   end

   // Pipeline registers with synchronous active-low reset to a neutral ADD
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_valid_q  <= 1'b0;
         a_opnum1_q <= '0;
         a_opnum2_q <= '0;
         a_func_q   <= `ALUFunc_ADD;
         a_rd_q     <= 5'd0;
         b_valid_q  <= 1'b0;
         b_res_q    <= '0;
         b_rd_q     <= 5'd0;
      end else begin
         a_valid_q  <= a_valid_d;
         a_opnum1_q <= a_opnum1_d;
         a_opnum2_q <= a_opnum2_d;
         a_func_q   <= a_func_d;
         a_rd_q     <= a_rd_d;
         b_valid_q  <= b_valid_d;
         b_res_q    <= b_res_d;
         b_rd_q     <= b_rd_d;
      end
   end

   // The ALU is driven straight from stage A so its result is ready for B
   assign alu_eval_en = a_valid_q;
   assign alu_opnum1  = a_opnum1_q;
   assign alu_opnum2  = a_opnum2_q;
   assign alu_func    = a_func_q;

   assign out_valid   = b_valid_q;
   assign out_res     = b_res_q;
   assign out_rd_addr = b_rd_q;

endmodule

`default_nettype wire
